apb_timer_slave: RTL and testbench

//   APB slave placed directly downstream of the AHB-to-APB bridge, on the same HCLK with PCLKEN qualification.

---
 rtl/apb_timer_slave_if.sv | 36 +++
 rtl/apb_timer_slave.sv | 172 +++++++++++++++++
 tb/tb_apb_timer_slave.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_timer_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_timer_slave_if
// Description : APB bus bundle between the AHB-to-APB bridge (master) and
//               the timer slave. PCLKEN travels with the bus because it
//               qualifies every APB phase.
//               master modport: drives PCLKEN, PSEL, PENABLE, PADDR, PWRITE,
//                               PWDATA; receives PRDATA, PREADY, PSLVERR
//               slave  modport: the reverse
// Revision    : 1.0  initial release
// ============================================================================
interface apb_timer_slave_if #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
);
    logic                 PCLKEN;
    logic                 PSEL;
    logic                 PENABLE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic                 PWRITE;
    logic [DATAWIDTH-1:0] PWDATA;
    logic [DATAWIDTH-1:0] PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    modport master (
        output PCLKEN, PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PCLKEN, PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/apb_timer_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_timer_slave
// Description : APB slave with a 32-bit down-counting timer, 8-bit prescaler,
//               reload, one-shot mode and a level interrupt. Optional PREADY
//               wait states and PSLVERR on unmapped offsets.
//   HCLK       in  clock (shared with the bridge)
//   HRESET     in  synchronous reset, active-high
//   bus        slave modport: PCLKEN/PSEL/PENABLE/PADDR/PWRITE/PWDATA in,
//              PRDATA/PREADY/PSLVERR out
//   TIMER_IRQ  out interrupt level = INTSTATUS & CTRL.IRQEN
// Revision    : 1.0  initial release
// ============================================================================
module apb_timer_slave #(
    parameter int ADDRWIDTH       = 16,
    parameter int DATAWIDTH       = 32,
    parameter int WAIT_STATES     = 0,
    parameter bit ERR_ON_UNMAPPED = 1'b1
) (
    input  logic             HCLK,
    input  logic             HRESET,
    apb_timer_slave_if.slave bus,
    output logic             TIMER_IRQ
);
    localparam logic [2:0] c_addr_ctrl     = 3'd0;
    localparam logic [2:0] c_addr_reload   = 3'd1;
    localparam logic [2:0] c_addr_value    = 3'd2;
    localparam logic [2:0] c_addr_prescale = 3'd3;
    localparam logic [2:0] c_addr_int      = 3'd4;
    localparam logic [3:0] c_wait          = 4'(WAIT_STATES);

    logic [ADDRWIDTH-1:0] w_paddr;
    logic [DATAWIDTH-1:0] w_pwdata;
    logic [2:0]           w_idx;
    logic                 w_unused;

    assign w_paddr  = bus.PADDR;
    assign w_pwdata = bus.PWDATA;
    assign w_idx    = w_paddr[4:2];
    // Byte-lane bits and the upper address bits carry no decode information.
    assign w_unused = ^{w_paddr[ADDRWIDTH-1:5], w_paddr[1:0]};

    // ------------------------------------------------------------------
    // Wait-state counter. It counts elapsed wait states upward and the
    // access completes once it reaches WAIT_STATES; this is equivalent to
    // loading WAIT_STATES and counting down, but lets the reset value of 0
    // give PREADY=0 after reset whenever wait states are configured.
    // ------------------------------------------------------------------
    logic [3:0] r_wait_cnt;
    logic       w_ready;

    assign w_ready = (r_wait_cnt == c_wait);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_wait_cnt <= 4'd0;
        end else if (bus.PCLKEN) begin
            if (bus.PSEL && !bus.PENABLE) begin
                r_wait_cnt <= 4'd0;
            end else if (bus.PSEL && bus.PENABLE && !w_ready) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file and timer
    // ------------------------------------------------------------------
    logic [2:0]  r_ctrl;        // [0]=EN [1]=IRQEN [2]=ONESHOT
    logic [31:0] r_reload;
    logic [31:0] r_value;
    logic [7:0]  r_prescale;
    logic [7:0]  r_pre_cnt;
    logic        r_int;

    logic w_commit, w_wr;
    logic w_wr_ctrl, w_wr_reload, w_wr_value, w_wr_pre, w_wr_int;
    logic w_tick, w_expire;

    assign w_commit    = bus.PSEL & bus.PENABLE & w_ready & bus.PCLKEN;
    assign w_wr        = w_commit & bus.PWRITE;
    assign w_wr_ctrl   = w_wr & (w_idx == c_addr_ctrl);
    assign w_wr_reload = w_wr & (w_idx == c_addr_reload);
    assign w_wr_value  = w_wr & (w_idx == c_addr_value);
    assign w_wr_pre    = w_wr & (w_idx == c_addr_prescale);
    assign w_wr_int    = w_wr & (w_idx == c_addr_int);

    assign w_tick   = bus.PCLKEN & r_ctrl[0] & (r_pre_cnt == r_prescale);
    assign w_expire = w_tick & (r_value == 32'd0);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_ctrl     <= 3'd0;
            r_reload   <= 32'd0;
            r_value    <= 32'd0;
            r_prescale <= 8'd0;
            r_pre_cnt  <= 8'd0;
            r_int      <= 1'b0;
        end else begin
            // A bus write to CTRL overrides the one-shot auto-disable.
            if (w_wr_ctrl) begin
                r_ctrl <= w_pwdata[2:0];
            end else if (w_expire && r_ctrl[2]) begin
                r_ctrl[0] <= 1'b0;
            end

            if (w_wr_reload) begin
                r_reload <= w_pwdata;
            end

            // A bus write to VALUE discards a coincident tick.
            if (w_wr_value) begin
                r_value <= w_pwdata;
            end else if (w_tick) begin
                if (r_value != 32'd0) begin
                    r_value <= r_value - 32'd1;
                end else if (!r_ctrl[2]) begin
                    r_value <= r_reload;
                end
            end

            if (w_wr_pre) begin
                r_prescale <= w_pwdata[7:0];
                r_pre_cnt  <= 8'd0;
            end else if (bus.PCLKEN && r_ctrl[0]) begin
                r_pre_cnt <= (r_pre_cnt == r_prescale) ? 8'd0 : r_pre_cnt + 8'd1;
            end

            // Expiry beats a simultaneous write-1-to-clear.
            if (w_expire) begin
                r_int <= 1'b1;
            end else if (w_wr_int && w_pwdata[0]) begin
                r_int <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux and response
    // ------------------------------------------------------------------
    logic [DATAWIDTH-1:0] w_rdata;
    logic                 w_unmapped;

    assign w_unmapped = (w_idx > c_addr_int);

    always_comb begin
        w_rdata = '0;
        if (bus.PSEL && !bus.PWRITE) begin
            case (w_idx)
                c_addr_ctrl:     w_rdata = {29'd0, r_ctrl};
                c_addr_reload:   w_rdata = r_reload;
                c_addr_value:    w_rdata = r_value;
                c_addr_prescale: w_rdata = {24'd0, r_prescale};
                c_addr_int:      w_rdata = {31'd0, r_int};
                default:         w_rdata = '0;
            endcase
        end
    end

    assign bus.PRDATA = w_rdata;
    assign bus.PREADY = w_ready;
    assign TIMER_IRQ  = r_int & r_ctrl[1];

    generate
        if (ERR_ON_UNMAPPED) begin : g_err_resp
            assign bus.PSLVERR = bus.PSEL & bus.PENABLE & w_ready & w_unmapped;
        end else begin : g_no_err_resp
            assign bus.PSLVERR = 1'b0;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_apb_timer_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_timer_slave
// Description : Self-checking bench for apb_timer_slave. dut0 has no wait
//               states and is tracked by a cycle-level reference model;
//               dut2 has two wait states and no error response.
// Revision    : 1.0  initial release
// ============================================================================
module tb_apb_timer_slave;
    logic HCLK = 1'b0;
    logic HRESET;
    logic irq0, irq2;
    int   total = 0;
    int   bad   = 0;

    always #5 HCLK = ~HCLK;

    apb_timer_slave_if #(.ADDRWIDTH(16), .DATAWIDTH(32)) bus  ();
    apb_timer_slave_if #(.ADDRWIDTH(16), .DATAWIDTH(32)) bus2 ();

    apb_timer_slave #(.ADDRWIDTH(16), .DATAWIDTH(32), .WAIT_STATES(0), .ERR_ON_UNMAPPED(1'b1))
        dut0 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus), .TIMER_IRQ(irq0));
    apb_timer_slave #(.ADDRWIDTH(16), .DATAWIDTH(32), .WAIT_STATES(2), .ERR_ON_UNMAPPED(1'b0))
        dut2 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus2), .TIMER_IRQ(irq2));

    // Reference model of dut0's programmer-visible state.
    logic [2:0]  m_ctrl;
    logic [31:0] m_reload, m_value;
    logic [7:0]  m_prescale;
    bit          m_int;
    int          m_phase;   // enabled cycles since the last tick

    task automatic model_update();
        bit tick, expire;
        logic [31:0] d;
        if (HRESET) begin
            m_ctrl = 0; m_reload = 0; m_value = 0; m_prescale = 0; m_int = 0; m_phase = 0;
            return;
        end
        tick = 0;
        if (bus.PCLKEN && m_ctrl[0]) begin
            m_phase++;
            if (m_phase == m_prescale + 1) begin tick = 1; m_phase = 0; end
        end
        expire = tick && (m_value == 0);
        if (tick) m_value = (m_value != 0) ? m_value - 1 : (m_ctrl[2] ? 32'd0 : m_reload);
        if (expire) begin m_int = 1; if (m_ctrl[2]) m_ctrl[0] = 1'b0; end
        d = bus.PWDATA;
        if (bus.PSEL && bus.PENABLE && bus.PCLKEN && bus.PWRITE) begin
            case (bus.PADDR[4:2])
                3'd0: m_ctrl = d[2:0];
                3'd1: m_reload = d;
                3'd2: m_value = d;
                3'd3: begin m_prescale = d[7:0]; m_phase = 0; end
                3'd4: if (d[0] && !expire) m_int = 0;
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] exp_read(input int idx);
        case (idx)
            0: return {29'd0, m_ctrl};
            1: return m_reload;
            2: return m_value;
            3: return {24'd0, m_prescale};
            4: return {31'd0, m_int};
            default: return 32'd0;
        endcase
    endfunction

    task automatic step();
        model_update();
        @(posedge HCLK);
        #1;
    endtask

    task automatic peek(input logic [15:0] a, output logic [31:0] d);
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = a;
        #1;
        d = bus.PRDATA;
        bus.PSEL = 0;
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        bus.PCLKEN = 1; bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = a; bus.PWDATA = d;
        step();
        bus.PENABLE = 1;
        step();
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic e, output logic r);
        bus.PCLKEN = 1; bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = a;
        step();
        bus.PENABLE = 1;
        #1;
        d = bus.PRDATA; e = bus.PSLVERR; r = bus.PREADY;
        step();
        bus.PSEL = 0; bus.PENABLE = 0;
    endtask

    task automatic bus2_access(input logic [15:0] a, input bit wr, input logic [31:0] wd,
                               input bit toggle, output logic [31:0] d, output logic e, output int waits);
        bus2.PCLKEN = 1; bus2.PSEL = 1; bus2.PENABLE = 0; bus2.PWRITE = wr; bus2.PADDR = a; bus2.PWDATA = wd;
        step();
        bus2.PENABLE = 1;
        waits = 0;
        while (bus2.PREADY !== 1'b1 && waits < 40) begin
            bus2.PCLKEN = toggle ? (waits % 2 == 1) : 1'b1;
            step();
            waits++;
        end
        bus2.PCLKEN = 1;
        #1;
        d = bus2.PRDATA; e = bus2.PSLVERR;
        step();
        bus2.PSEL = 0; bus2.PENABLE = 0; bus2.PWRITE = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e, r;
        HRESET = 1;
        step(); step();
        total++; if (bus.PREADY !== 1'b1) begin bad++; $display("FAIL reset_pready0: got %b want 1", bus.PREADY); end
        total++; if (bus2.PREADY !== 1'b0) begin bad++; $display("FAIL reset_pready2: got %b want 0", bus2.PREADY); end
        total++; if (bus.PSLVERR !== 1'b0) begin bad++; $display("FAIL reset_pslverr: got %b want 0", bus.PSLVERR); end
        total++; if (bus.PRDATA !== 32'd0) begin bad++; $display("FAIL reset_prdata: got %h want 0", bus.PRDATA); end
        total++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b%b want 00", irq0, irq2); end
        HRESET = 0;
        for (int i = 0; i < 5; i++) begin
            apb_read(16'(i * 4), d, e, r);
            total++; if (d !== 32'd0 || e !== 1'b0) begin bad++; $display("FAIL reset_read idx%0d: got %h err %b want 0 err 0", i, d, e); end
        end
    endtask

    task automatic test_periodic();
        logic [31:0] d;
        logic [31:0] seq [5];
        seq = '{32'd2, 32'd1, 32'd0, 32'd3, 32'd2};
        apb_write(16'h04, 3); apb_write(16'h08, 3); apb_write(16'h0C, 0); apb_write(16'h00, 3);
        for (int i = 1; i <= 5; i++) begin
            step();
            peek(16'h08, d);
            total++; if (d !== seq[i-1] || d !== m_value) begin bad++; $display("FAIL periodic_value cyc%0d: got %h want %h", i, d, seq[i-1]); end
            total++; if (irq0 !== (i >= 4)) begin bad++; $display("FAIL periodic_irq cyc%0d: got %b want %b", i, irq0, (i >= 4)); end
        end
        apb_write(16'h00, 2);
        apb_write(16'h10, 1);
        peek(16'h10, d);
        total++; if (d !== 32'd0 || irq0 !== 1'b0) begin bad++; $display("FAIL w1c_clear: got int %h irq %b want 0 0", d, irq0); end
    endtask

    task automatic test_prescale_oneshot();
        logic [31:0] d; logic e, r;
        apb_write(16'h00, 0); apb_write(16'h0C, 1); apb_write(16'h08, 5); apb_write(16'h00, 1);
        for (int i = 0; i < 16; i++) begin
            bus.PCLKEN = (i % 2 == 0);
            step();
            peek(16'h08, d);
            total++; if (d !== m_value) begin bad++; $display("FAIL prescale_value cyc%0d: got %h want %h", i, d, m_value); end
        end
        total++; if (d !== 32'd1) begin bad++; $display("FAIL prescale_final: got %h want 1", d); end
        bus.PCLKEN = 1;
        apb_write(16'h00, 0); apb_write(16'h0C, 0); apb_write(16'h08, 1); apb_write(16'h00, 5);
        for (int i = 0; i < 8; i++) begin
            step();
            peek(16'h08, d);
            total++; if (d !== m_value) begin bad++; $display("FAIL oneshot_value cyc%0d: got %h want %h", i, d, m_value); end
        end
        apb_read(16'h00, d, e, r);
        total++; if (d !== 32'd4) begin bad++; $display("FAIL oneshot_ctrl: got %h want 4", d); end
        peek(16'h08, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL oneshot_hold: got %h want 0", d); end
        peek(16'h10, d);
        total++; if (d !== 32'd1 || irq0 !== 1'b0) begin bad++; $display("FAIL oneshot_int: got %h irq %b want 1 0", d, irq0); end
    endtask

    task automatic test_collisions();
        logic [31:0] d;
        apb_write(16'h00, 0); apb_write(16'h0C, 0); apb_write(16'h08, 10); apb_write(16'h00, 1);
        apb_write(16'h08, 32'h55);
        peek(16'h08, d);
        total++; if (d !== 32'h55 || d !== m_value) begin bad++; $display("FAIL value_write_vs_tick: got %h want 55", d); end
        apb_write(16'h00, 0); apb_write(16'h04, 0); apb_write(16'h08, 0); apb_write(16'h00, 1);
        apb_write(16'h10, 1);
        peek(16'h10, d);
        total++; if (d !== 32'd1) begin bad++; $display("FAIL w1c_vs_expiry: got %h want 1", d); end
        apb_write(16'h00, 0);
        apb_write(16'h10, 1);
        peek(16'h10, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL w1c_idle: got %h want 0", d); end
    endtask

    task automatic test_wait_states();
        logic [31:0] d; logic e; int w;
        bus2_access(16'h04, 1'b1, 32'hDEADBEEF, 1'b0, d, e, w);
        total++; if (w !== 2) begin bad++; $display("FAIL ws_write_waits: got %0d want 2", w); end
        bus2_access(16'h04, 1'b0, 32'd0, 1'b0, d, e, w);
        total++; if (w !== 2 || d !== 32'hDEADBEEF) begin bad++; $display("FAIL ws_read: got waits %0d data %h want 2 deadbeef", w, d); end
        bus2_access(16'h04, 1'b0, 32'd0, 1'b1, d, e, w);
        total++; if (w !== 4 || d !== 32'hDEADBEEF) begin bad++; $display("FAIL ws_pclken_read: got waits %0d data %h want 4 deadbeef", w, d); end
        bus2_access(16'h18, 1'b0, 32'd0, 1'b0, d, e, w);
        total++; if (e !== 1'b0 || d !== 32'd0) begin bad++; $display("FAIL ws_unmapped_noerr: got err %b data %h want 0 0", e, d); end
    endtask

    task automatic test_unmapped_reset();
        logic [31:0] d; logic e, r; int w;
        apb_read(16'h18, d, e, r);
        total++; if (d !== 32'd0 || e !== 1'b1 || r !== 1'b1) begin bad++; $display("FAIL unmapped_read: got %h err %b rdy %b want 0 1 1", d, e, r); end
        apb_write(16'h04, 32'h0000_0077);
        apb_write(16'h1C, 32'hFFFF_FFFF);
        apb_read(16'h04, d, e, r);
        total++; if (d !== m_reload || d !== 32'h77) begin bad++; $display("FAIL unmapped_write: got %h want 77", d); end
        // dut0: reset lands on the commit edge
        bus.PCLKEN = 1; bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 16'h04; bus.PWDATA = 32'hAAAA5555;
        step();
        bus.PENABLE = 1; HRESET = 1;
        step();
        HRESET = 0; bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
        apb_read(16'h04, d, e, r);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_mid_access0: got %h want 0", d); end
        // dut2: reset while the access is still being stretched
        bus2.PCLKEN = 1; bus2.PSEL = 1; bus2.PENABLE = 0; bus2.PWRITE = 1; bus2.PADDR = 16'h04; bus2.PWDATA = 32'h1111;
        step();
        bus2.PENABLE = 1;
        step();
        HRESET = 1;
        step();
        total++; if (bus2.PREADY !== 1'b0) begin bad++; $display("FAIL reset_mid_pready2: got %b want 0", bus2.PREADY); end
        HRESET = 0; bus2.PSEL = 0; bus2.PENABLE = 0; bus2.PWRITE = 0;
        bus2_access(16'h04, 1'b0, 32'd0, 1'b0, d, e, w);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_mid_access2: got %h want 0", d); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            int op, idx;
            logic [31:0] d, got;
            logic e, r;
            op  = $urandom_range(0, 3);
            idx = $urandom_range(0, 7);
            case (op)
                0: begin
                    case (idx)
                        0: d = $urandom_range(0, 7);
                        1: d = $urandom_range(0, 4);
                        2: d = $urandom_range(0, 6);
                        3: d = $urandom_range(0, 2);
                        4: d = $urandom_range(0, 1);
                        default: d = $urandom;
                    endcase
                    apb_write(16'(idx * 4), d);
                end
                1: begin
                    repeat ($urandom_range(1, 6)) begin
                        bus.PCLKEN = 1'($urandom_range(0, 1));
                        step();
                    end
                    total++; if (irq0 !== (m_int & m_ctrl[1])) begin bad++; $display("FAIL rand_irq it%0d: got %b want %b", n, irq0, m_int & m_ctrl[1]); end
                end
                2: begin
                    apb_read(16'(idx * 4 + $urandom_range(0, 3)), got, e, r);
                    // read data reflects state before the setup edge's model step was applied
                    total++; if (e !== (idx > 4)) begin bad++; $display("FAIL rand_err it%0d: got %b want %b", n, e, (idx > 4)); end
                    peek(16'(idx * 4), got);
                    total++; if (got !== exp_read(idx)) begin bad++; $display("FAIL rand_read it%0d idx%0d: got %h want %h", n, idx, got, exp_read(idx)); end
                end
                default: begin
                    for (int k = 0; k < 5; k++) begin
                        peek(16'(k * 4), got);
                        total++; if (got !== exp_read(k)) begin bad++; $display("FAIL rand_peek it%0d idx%0d: got %h want %h", n, k, got, exp_read(k)); end
                    end
                end
            endcase
        end
    endtask

    initial begin
        HRESET = 1;
        bus.PCLKEN = 1;  bus.PSEL = 0;  bus.PENABLE = 0;  bus.PWRITE = 0;  bus.PADDR = 0;  bus.PWDATA = 0;
        bus2.PCLKEN = 1; bus2.PSEL = 0; bus2.PENABLE = 0; bus2.PWRITE = 0; bus2.PADDR = 0; bus2.PWDATA = 0;
        m_ctrl = 0; m_reload = 0; m_value = 0; m_prescale = 0; m_int = 0; m_phase = 0;
        @(posedge HCLK); #1;
        test_reset();
        test_periodic();
        test_prescale_oneshot();
        test_collisions();
        test_wait_states();
        test_unmapped_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
